reg_file: RTL and testbench

//  Architectural register file for the async CPU. It is the responder at the far end of the

---
 rtl/async_cpu_pkg.sv | 24 ++
 rtl/reg_file.sv | 126 ++++++++++++
 tb/tb_reg_file.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/async_cpu_pkg.sv
// Shared definitions for the async CPU slice.
// Holds the handshake FSM state types used by the register file and the
// default datapath widths shared by writeback, decode and the register file.
package async_cpu_pkg;

  // Default widths. Modules keep their own DATA_W/ADDR_W parameters and
  // take these values as their defaults.
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  // Write-port handshake: commit, pulse ack, then wait for the request to drop.
  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_ACK     = 2'd1,
    W_RELEASE = 2'd2
  } wr_state_t;

  // Read-port 4-phase handshake.
  typedef enum logic {
    R_IDLE = 1'b0,
    R_ACK  = 1'b1
  } rd_state_t;

endpackage

// File: rtl/reg_file.sv
// reg_file: architectural register file for the async CPU.
//
// Write port (responder side of the writeback handshake):
//   write_en, write_addr, write_data  in : request held until reg_ack is seen
//   reg_ack                           out: one-cycle commit acknowledge
// Read port (4-phase handshake with decode):
//   rd_req, rd_addr_a, rd_addr_b      in : request and operand addresses
//   rd_data_a, rd_data_b, rd_ack      out: captured operands, ack held until rd_req drops
// clk : single clock, rst : asynchronous active-high reset.
//
// A write committing on the same edge a read is captured is forwarded into
// the read data. With ZERO_REG != 0, R0 always reads 0 and writes to it are
// dropped (still acknowledged).
module reg_file
  import async_cpu_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              reg_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_ack
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  wr_state_t         wr_state_reg;
  rd_state_t         rd_state_reg;

  // A write is committed only from W_IDLE; this is the same condition used
  // for forwarding, so a forwarded value is always one that actually lands.
  logic wr_commit;
  assign wr_commit = (wr_state_reg == W_IDLE) && write_en;

  // Read value for one operand, including same-edge write forwarding.
  function automatic logic [DATA_W-1:0] rdval(input logic [ADDR_W-1:0] x);
    if ((ZERO_REG != 0) && (x == '0))
      return '0;
    else if (wr_commit && (write_addr == x))
      return write_data;
    else
      return regs[x];
  endfunction

  // Write FSM and storage. Storage is reset as a whole, so it lives in
  // flops rather than block RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_reg <= W_IDLE;
      reg_ack      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (wr_state_reg)
        W_IDLE: begin
          if (write_en) begin
            if (!((ZERO_REG != 0) && (write_addr == '0))) begin
              regs[write_addr] <= write_data;
            end
            reg_ack      <= 1'b1;
            wr_state_reg <= W_ACK;
          end
        end
        W_ACK: begin
          // Writeback has not yet seen the ack, so write_en is still high
          // here; moving to W_RELEASE keeps it from being committed twice.
          reg_ack      <= 1'b0;
          wr_state_reg <= W_RELEASE;
        end
        W_RELEASE: begin
          if (!write_en) begin
            wr_state_reg <= W_IDLE;
          end
        end
        default: begin
          reg_ack      <= 1'b0;
          wr_state_reg <= W_IDLE;
        end
      endcase
    end
  end

  // Read FSM: capture once per rd_req rising phase, hold until it drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_reg <= R_IDLE;
      rd_ack       <= 1'b0;
      rd_data_a    <= '0;
      rd_data_b    <= '0;
    end else begin
      case (rd_state_reg)
        R_IDLE: begin
          if (rd_req) begin
            rd_data_a    <= rdval(rd_addr_a);
            rd_data_b    <= rdval(rd_addr_b);
            rd_ack       <= 1'b1;
            rd_state_reg <= R_ACK;
          end
        end
        R_ACK: begin
          if (!rd_req) begin
            rd_ack       <= 1'b0;
            rd_state_reg <= R_IDLE;
          end
        end
        default: begin
          rd_ack       <= 1'b0;
          rd_state_reg <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed testbench for reg_file. Two instances share all inputs:
// dut_z (ZERO_REG = 1) and dut_n (ZERO_REG = 0).
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_en;
  logic [3:0]  write_addr;
  logic [15:0] write_data;
  logic        rd_req;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;

  logic        reg_ack_z, rd_ack_z;
  logic [15:0] rd_data_a_z, rd_data_b_z;
  logic        reg_ack_n, rd_ack_n;
  logic [15:0] rd_data_a_n, rd_data_b_n;

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  reg_file #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .reg_ack(reg_ack_z),
    .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a_z), .rd_data_b(rd_data_b_z), .rd_ack(rd_ack_z)
  );

  reg_file #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) dut_n (
    .clk(clk), .rst(rst),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .reg_ack(reg_ack_n),
    .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a_n), .rd_data_b(rd_data_b_n), .rd_ack(rd_ack_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full write handshake; writeback holds write_en through the W_ACK edge
  // plus 'extra' cycles, then drops it.
  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input int extra,
                          input string name);
    @(negedge clk);
    write_en = 1'b1; write_addr = a; write_data = d;
    tick();
    total_cnt++;
    if ({reg_ack_z, reg_ack_n} !== 2'b11)
      $display("FAIL %s ack_pulse: got z=%b n=%b want 1/1", name, reg_ack_z, reg_ack_n);
    else pass_cnt++;
    for (int k = 0; k <= extra; k++) begin
      @(negedge clk);
      tick();
      total_cnt++;
      if ({reg_ack_z, reg_ack_n} !== 2'b00)
        $display("FAIL %s ack_low_%0d: got z=%b n=%b want 0/0", name, k, reg_ack_z, reg_ack_n);
      else pass_cnt++;
    end
    @(negedge clk);
    write_en = 1'b0;
    tick();
    total_cnt++;
    if ({reg_ack_z, reg_ack_n} !== 2'b00)
      $display("FAIL %s ack_after_drop: got z=%b n=%b want 0/0", name, reg_ack_z, reg_ack_n);
    else pass_cnt++;
    $display("write %s: R%0d <= %h (held %0d extra)", name, a, d, extra);
  endtask

  // Full read handshake with expected data for both instances.
  task automatic do_read(input logic [3:0] a, input logic [3:0] b,
                         input logic [15:0] ea_z, input logic [15:0] eb_z,
                         input logic [15:0] ea_n, input logic [15:0] eb_n,
                         input string name);
    @(negedge clk);
    rd_req = 1'b1; rd_addr_a = a; rd_addr_b = b;
    tick();
    total_cnt++;
    if ({rd_ack_z, rd_ack_n} !== 2'b11 || rd_data_a_z !== ea_z || rd_data_b_z !== eb_z ||
        rd_data_a_n !== ea_n || rd_data_b_n !== eb_n)
      $display("FAIL %s read: got ack=%b%b z=%h/%h n=%h/%h want ack=11 z=%h/%h n=%h/%h",
               name, rd_ack_z, rd_ack_n, rd_data_a_z, rd_data_b_z, rd_data_a_n, rd_data_b_n,
               ea_z, eb_z, ea_n, eb_n);
    else pass_cnt++;
    @(negedge clk);
    rd_req = 1'b0;
    tick();
    total_cnt++;
    if ({rd_ack_z, rd_ack_n} !== 2'b00)
      $display("FAIL %s rd_ack_release: got %b%b want 00", name, rd_ack_z, rd_ack_n);
    else pass_cnt++;
    $display("read %s: A=R%0d B=R%0d z=%h/%h n=%h/%h", name, a, b,
             rd_data_a_z, rd_data_b_z, rd_data_a_n, rd_data_b_n);
  endtask

  task automatic test_reset();
    rst = 1'b1; write_en = 1'b0; write_addr = '0; write_data = '0;
    rd_req = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    repeat (2) tick();
    total_cnt++;
    if ({reg_ack_z, rd_ack_z, reg_ack_n, rd_ack_n} !== 4'b0000 ||
        rd_data_a_z !== 16'h0 || rd_data_b_z !== 16'h0)
      $display("FAIL reset_outputs: got acks=%b%b%b%b data=%h/%h want 0000 0000/0000",
               reg_ack_z, rd_ack_z, reg_ack_n, rd_ack_n, rd_data_a_z, rd_data_b_z);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    do_read(4'd3, 4'd7, 16'h0, 16'h0, 16'h0, 16'h0, "reset_r3_r7");
  endtask

  task automatic test_write_hold();
    do_write(4'd5, 16'hBEEF, 1, "r5_beef");
    do_read(4'd5, 4'd5, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, "r5_readback");
  endtask

  task automatic test_zero_reg();
    do_write(4'd0, 16'h1234, 0, "r0_1234");
    do_read(4'd0, 4'd0, 16'h0000, 16'h0000, 16'h1234, 16'h1234, "r0_readback");
  endtask

  task automatic test_forward();
    do_write(4'd2, 16'h0011, 0, "r2_0011");
    @(negedge clk);
    write_en = 1'b1; write_addr = 4'd9; write_data = 16'hA5A5;
    rd_req = 1'b1; rd_addr_a = 4'd9; rd_addr_b = 4'd2;
    tick();
    total_cnt++;
    if ({reg_ack_z, rd_ack_z} !== 2'b11 || rd_data_a_z !== 16'hA5A5 || rd_data_b_z !== 16'h0011 ||
        rd_data_a_n !== 16'hA5A5 || rd_data_b_n !== 16'h0011)
      $display("FAIL forward: got acks=%b%b z=%h/%h n=%h/%h want 11 a5a5/0011",
               reg_ack_z, rd_ack_z, rd_data_a_z, rd_data_b_z, rd_data_a_n, rd_data_b_n);
    else pass_cnt++;
    @(negedge clk);
    tick();
    @(negedge clk);
    write_en = 1'b0; rd_req = 1'b0;
    tick();
    total_cnt++;
    if ({reg_ack_z, rd_ack_z} !== 2'b00)
      $display("FAIL forward_release: got acks=%b%b want 00", reg_ack_z, rd_ack_z);
    else pass_cnt++;
    $display("forward: R9 <= a5a5 with same-edge read of R9/R2");
    do_read(4'd9, 4'd2, 16'hA5A5, 16'h0011, 16'hA5A5, 16'h0011, "r9_readback");
  endtask

  task automatic test_read_hold();
    @(negedge clk);
    rd_req = 1'b1; rd_addr_a = 4'd5; rd_addr_b = 4'd9;
    for (int k = 0; k < 5; k++) begin
      tick();
      total_cnt++;
      if (rd_ack_z !== 1'b1 || rd_data_a_z !== 16'hBEEF || rd_data_b_z !== 16'hA5A5)
        $display("FAIL hold_%0d: got ack=%b data=%h/%h want 1 beef/a5a5",
                 k, rd_ack_z, rd_data_a_z, rd_data_b_z);
      else pass_cnt++;
      // Moving the addresses while held must not cause a re-capture.
      @(negedge clk);
      rd_addr_a = 4'd2; rd_addr_b = 4'd2;
    end
    rd_req = 1'b0;
    tick();
    total_cnt++;
    if (rd_ack_z !== 1'b0)
      $display("FAIL hold_release: got rd_ack=%b want 0", rd_ack_z);
    else pass_cnt++;
    $display("read hold: 5 cycles stable, released");
    do_read(4'd2, 4'd5, 16'h0011, 16'hBEEF, 16'h0011, 16'hBEEF, "recapture");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    write_en = 1'b1; write_addr = 4'd3; write_data = 16'h7777;
    rd_req = 1'b1; rd_addr_a = 4'd5; rd_addr_b = 4'd9;
    tick();
    total_cnt++;
    if ({reg_ack_z, rd_ack_z} !== 2'b11)
      $display("FAIL pre_reset_acks: got %b%b want 11", reg_ack_z, rd_ack_z);
    else pass_cnt++;
    #1;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({reg_ack_z, rd_ack_z, reg_ack_n, rd_ack_n} !== 4'b0000 || rd_data_a_z !== 16'h0 ||
        rd_data_b_z !== 16'h0)
      $display("FAIL async_reset: got acks=%b%b%b%b data=%h/%h want 0000 0000/0000",
               reg_ack_z, rd_ack_z, reg_ack_n, rd_ack_n, rd_data_a_z, rd_data_b_z);
    else pass_cnt++;
    @(negedge clk);
    write_en = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    $display("async reset mid-handshake applied");
    for (int i = 0; i < 8; i++) begin
      do_read(4'(i), 4'(i + 8), 16'h0, 16'h0, 16'h0, 16'h0, $sformatf("cleared_%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_write_hold();
    test_zero_reg();
    test_forward();
    test_read_hold();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
